// File: rtl/score_input_conditioner_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the score input conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package score_input_conditioner_pkg;

  // Debounce cell states
  typedef enum logic [1:0] {
    DB_IDLE         = 2'd0,
    DB_PRESS_WAIT   = 2'd1,
    DB_HELD         = 2'd2,
    DB_RELEASE_WAIT = 2'd3
  } db_state_t;

  localparam int CNT_W               = 24;
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;  // 10 ms at 100 MHz
  localparam int SYNC_STAGES_DEF     = 2;

  // One debounce cell per raw input, in this bit order
  localparam int NUM_INPUTS  = 7;
  localparam int IDX_ONE     = 0;
  localparam int IDX_TWO     = 1;
  localparam int IDX_THREE   = 2;
  localparam int IDX_PAUSE   = 3;
  localparam int IDX_RST_PTS = 4;
  localparam int IDX_RST_SCR = 5;
  localparam int IDX_TEAM    = 6;

  // A button counts as "down" once accepted until its release is confirmed
  function automatic logic is_stable(db_state_t s);
    return (s == DB_HELD) || (s == DB_RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/score_input_conditioner_if.sv
`timescale 1ns/1ps
// Raw button/switch inputs and conditioned outputs of the score input conditioner.
// Latency: n/a (wiring only).
// Backpressure: none; outputs are fire-and-forget pulses and levels.
interface score_input_conditioner_if;

  logic btn_one;
  logic btn_two;
  logic btn_three;
  logic btn_pause;
  logic btn_reset_points;
  logic btn_reset_score;
  logic sw_team;

  logic one_point;
  logic two_point;
  logic three_point;
  logic reset_points;
  logic reset_score;
  logic pause;
  logic team;
  logic busy;

  // Board / stimulus side: drives the raw inputs
  modport master (
    output btn_one, btn_two, btn_three, btn_pause,
           btn_reset_points, btn_reset_score, sw_team,
    input  one_point, two_point, three_point, reset_points,
           reset_score, pause, team, busy
  );

  // Conditioner side
  modport slave (
    input  btn_one, btn_two, btn_three, btn_pause,
           btn_reset_points, btn_reset_score, sw_team,
    output one_point, two_point, three_point, reset_points,
           reset_score, pause, team, busy
  );

endinterface

// File: rtl/score_input_conditioner_debounce_cell.sv
`timescale 1ns/1ps
// Synchronizes one raw input and debounces it; emits a press strobe and a stable level.
// Latency: strobe is combinational in the cycle the FSM enters HELD, SYNC_STAGES+DEBOUNCE_CYCLES after the raw edge.
// Backpressure: none; the strobe is a one-cycle event with no handshake.
module debounce_cell
  import score_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic strobe,
  output logic stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_in;
  db_state_t              state;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_sat;

  // Metastability synchronizer; nothing else looks at the raw input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  // Counter never wraps, so a very long wait can't alias to a short one
  assign cnt_sat = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  // Debounce FSM; the counter is cleared on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DB_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        DB_IDLE: begin
          if (sync_in) begin
            state <= DB_PRESS_WAIT;
            cnt   <= '0;
          end
        end
        DB_PRESS_WAIT: begin
          if (!sync_in) begin
            state <= DB_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= DB_HELD;
            cnt   <= '0;
          end else begin
            cnt <= cnt_sat;
          end
        end
        DB_HELD: begin
          // No auto-repeat while held
          if (!sync_in) begin
            state <= DB_RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        DB_RELEASE_WAIT: begin
          // Bounce on release returns to HELD silently
          if (sync_in) begin
            state <= DB_HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= DB_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt_sat;
          end
        end
        default: begin
          state <= DB_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign strobe = (state == DB_PRESS_WAIT) && sync_in && (cnt == CNT_LAST);
  assign stable = is_stable(state);

endmodule

// File: rtl/score_input_conditioner.sv
`timescale 1ns/1ps
// Debounces score/control buttons and the team switch; arbitrates and locks out score presses.
// Latency: raw stable edge to output pulse = SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles (+/-1 sampling phase).
// Backpressure: none; losing or locked-out score presses are dropped, never queued.
module score_input_conditioner
  import score_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input logic                        clk,
  input logic                        rst_n,
  score_input_conditioner_if.slave   bus
);

  logic [NUM_INPUTS-1:0] raw_vec;
  logic [NUM_INPUTS-1:0] strb;
  logic [NUM_INPUTS-1:0] stbl;

  logic [2:0] held;
  logic [2:0] accept;
  logic [2:0] sel;

  logic one_q, two_q, three_q;
  logic rst_pts_q, rst_scr_q, pause_q;

  assign raw_vec[IDX_ONE]     = bus.btn_one;
  assign raw_vec[IDX_TWO]     = bus.btn_two;
  assign raw_vec[IDX_THREE]   = bus.btn_three;
  assign raw_vec[IDX_PAUSE]   = bus.btn_pause;
  assign raw_vec[IDX_RST_PTS] = bus.btn_reset_points;
  assign raw_vec[IDX_RST_SCR] = bus.btn_reset_score;
  assign raw_vec[IDX_TEAM]    = bus.sw_team;

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
    ) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (raw_vec[g]),
      .strobe (strb[g]),
      .stable (stbl[g])
    );
  end

  assign held = {stbl[IDX_THREE], stbl[IDX_TWO], stbl[IDX_ONE]};

  // Lockout by another held score button, then fixed priority one > two > three
  always_comb begin
    accept = '0;
    sel    = '0;
    accept[0] = strb[IDX_ONE]   & ~(held[1] | held[2]);
    accept[1] = strb[IDX_TWO]   & ~(held[0] | held[2]);
    accept[2] = strb[IDX_THREE] & ~(held[0] | held[1]);
    if (accept[0])      sel = 3'b001;
    else if (accept[1]) sel = 3'b010;
    else if (accept[2]) sel = 3'b100;
  end

  // Registered output pulses and the pause toggle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      one_q     <= 1'b0;
      two_q     <= 1'b0;
      three_q   <= 1'b0;
      rst_pts_q <= 1'b0;
      rst_scr_q <= 1'b0;
      pause_q   <= 1'b0;
    end else begin
      one_q     <= sel[0];
      two_q     <= sel[1];
      three_q   <= sel[2];
      rst_pts_q <= strb[IDX_RST_PTS];
      rst_scr_q <= strb[IDX_RST_SCR];
      pause_q   <= pause_q ^ strb[IDX_PAUSE];
    end
  end

  assign bus.one_point    = one_q;
  assign bus.two_point    = two_q;
  assign bus.three_point  = three_q;
  assign bus.reset_points = rst_pts_q;
  assign bus.reset_score  = rst_scr_q;
  assign bus.pause        = pause_q;
  // Team level is decoded straight from the cell's state register
  assign bus.team         = stbl[IDX_TEAM];
  assign bus.busy         = |held;

endmodule
